afe_rx_iq_deinterleaver: RTL and testbench
==========================================

// Module: afe_rx_iq_deinterleaver
// PURPOSE
//  Receive end of the AFE interleaved-IQ sample bus. Samples the 12-bit multiplexed
//  afe_rx_d/afe_rx_sel words, aligns to I/Q word order and pairs them into
//  24-bit {I,Q} samples (IQ_PAIR_WIDTH). Buffers the pairs in a show-ahead FIFO toward
//  the FT upstream path, with sync-loss detection, lock status and overflow reporting.
// PARAMETERS
//  SAMPLE_WIDTH   12  width of one I or Q word on afe_rx_d
//  FIFO_DEPTH     8   output FIFO depth in pairs; power of 2, >=2
//  LOCK_PAIRS     4   consecutive good pairs required before locked asserts
//  ERR_CNT_WIDTH  8   width of saturating sync-error counter
// PORTS
//  clk         in   1                 AFE sample clock; all logic on rising edge
//  reset       in   1                 synchronous, active-high
//  en          in   1                 1 = capture pairs; 0 = stop capture (FIFO still drains)
//  afe_rx_d    in   SAMPLE_WIDTH      multiplexed I/Q word from AFE
//  afe_rx_sel  in   1                 1 = word is I, 0 = word is Q
//  iq_data     out  2*SAMPLE_WIDTH    FIFO head, {I,Q}, I in MSBs
//  iq_valid    out  1                 FIFO not empty
//  iq_ready    in   1                 consumer accepts head when iq_valid & iq_ready
//  locked      out  1                 LOCK_PAIRS good pairs since last error/hunt
//  sync_err    out  1                 1-cycle pulse per ordering violation
//  err_cnt     out  ERR_CNT_WIDTH     saturating count of sync_err pulses
//  overflow    out  1                 sticky: a pair was dropped because the FIFO was full
//  ovf_clr     in   1                 clears overflow (set wins if same cycle)
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs currently held
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, iq_data=0, iq_valid=0, locked=0, sync_err=0,
//    err_cnt=0, overflow=0, fifo_level=0; held I and good-pair counter cleared.
//    Reset mid-stream discards the FIFO contents and any partial pair.
//  - Input stage: afe_rx_d/afe_rx_sel registered every clk (1 cycle); the FSM acts on
//    registered values (d_r, sel_r).
//  - FSM:
//    IDLE:     en=1 -> HUNT_I.
//    HUNT_I:   sel_r=1 -> hold I=d_r, go WAIT_Q; sel_r=0 -> word discarded, no error.
//    WAIT_Q:   sel_r=0 -> push {I,d_r}, go EXPECT_I;
//              sel_r=1 -> sync_err, drop old I, hold new I, stay WAIT_Q.
//    EXPECT_I: sel_r=1 -> hold I, go WAIT_Q; sel_r=0 -> sync_err, discard, go HUNT_I.
//    Any state with en=0 -> IDLE next edge; held I dropped, no push, no error.
//  - Lock: the good-pair counter increments per push and saturates at LOCK_PAIRS;
//    locked=1 when counter==LOCK_PAIRS. Any sync_err or entry to IDLE clears the
//    counter and locked in the same edge.
//  - err_cnt increments on each sync_err and saturates at all-ones (no wrap).
//  - FIFO: show-ahead; iq_valid=(level!=0), iq_data=head. Pop when iq_valid&iq_ready.
//    Push when not full, or when full with a pop in the same cycle (level unchanged).
//    Push when full without a pop: pair dropped, overflow set. Pop with empty: ignored.
//    Pointers wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH.
//  - Latency: Q word present on pins before edge k -> registered at k -> pushed at k+1 ->
//    iq_valid=1 after edge k+1 (FIFO previously empty).
//  - en=0 does not flush the FIFO; downstream may drain it.
// TESTING
//  1 Reset, en=1, ready=1, sel 1,0 x6 with I=0x123,Q=0x456 -> six 0x123456 outputs; first
//    iq_valid 2 clk after first Q on pins; locked rises with 4th push.
//  2 Locked stream, sel 1,0,1,1,0 (I=A,B) -> one sync_err pulse, err_cnt=1, locked=0,
//    next output {B,Q}; A never output.
//  3 iq_ready=0, push 10 pairs -> fifo_level=8, overflow=1, then ready=1 -> first 8 in
//    order; ovf_clr pulse -> overflow=0.
//  4 FIFO full, push and pop same cycle -> level stays 8, no overflow, new pair at tail.
//  5 en=0 between I and Q, then en=1 starting with a Q -> no push, no sync_err; next
//    I,Q pair output normally.
//  6 ERR_CNT_WIDTH=2, five violations -> err_cnt=3; reset mid-stream -> all outputs 0.

Source files
------------

// File: rtl/afe_rx_iq_deinterleaver_if.sv
// AFE interleaved-IQ bus: multiplexed sample input plus the paired {I,Q} stream output.
// The slave modport is the deinterleaver's view; master is the AFE/consumer side.
interface afe_rx_iq_deinterleaver_if #(
  parameter int SAMPLE_WIDTH = 12
);
  logic [SAMPLE_WIDTH-1:0]   afe_rx_d;
  logic                      afe_rx_sel;
  logic [2*SAMPLE_WIDTH-1:0] iq_data;
  logic                      iq_valid;
  logic                      iq_ready;

  modport slave (
    input  afe_rx_d,
    input  afe_rx_sel,
    input  iq_ready,
    output iq_data,
    output iq_valid
  );

  modport master (
    output afe_rx_d,
    output afe_rx_sel,
    output iq_ready,
    input  iq_data,
    input  iq_valid
  );
endinterface

// File: rtl/afe_rx_iq_deinterleaver.sv
// Pairs the AFE's multiplexed I/Q words into {I,Q} samples and buffers them in a
// show-ahead FIFO, tracking sync loss, lock status and overflow.
module afe_rx_iq_deinterleaver #(
  parameter int SAMPLE_WIDTH  = 12,
  parameter int FIFO_DEPTH    = 8,
  parameter int LOCK_PAIRS    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  afe_rx_iq_deinterleaver_if.slave     bus,
  output logic                         locked,
  output logic                         sync_err,
  output logic [ERR_CNT_WIDTH-1:0]     err_cnt,
  output logic                         overflow,
  input  logic                         ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PW = 2 * SAMPLE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(LOCK_PAIRS + 1);

  typedef enum logic [1:0] {IDLE, HUNT_I, WAIT_Q, EXPECT_I} state_t;

  state_t                  state, next_state;
  logic [SAMPLE_WIDTH-1:0] d_r;
  logic                    sel_r;
  logic [SAMPLE_WIDTH-1:0] i_hold;
  logic                    hold_ld;
  logic                    push;
  logic                    err_nxt;
  logic [CW-1:0]           good_cnt;

  logic [PW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    pop, full, wr_en, ovf_set;

  // ---- input stage: capture the pins every cycle
  always_ff @(posedge clk) begin
    d_r <= bus.afe_rx_d;
  end

  always_ff @(posedge clk) begin
    if (reset) sel_r <= 1'b0;
    else       sel_r <= bus.afe_rx_sel;
  end

  // ---- alignment FSM on the registered word
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    hold_ld    = 1'b0;
    push       = 1'b0;
    err_nxt    = 1'b0;
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:   next_state = HUNT_I;
        HUNT_I: begin
          if (sel_r) begin
            hold_ld    = 1'b1;
            next_state = WAIT_Q;
          end
        end
        WAIT_Q: begin
          if (sel_r) begin
            err_nxt = 1'b1;
            hold_ld = 1'b1;
          end else begin
            push       = 1'b1;
            next_state = EXPECT_I;
          end
        end
        EXPECT_I: begin
          if (sel_r) begin
            hold_ld    = 1'b1;
            next_state = WAIT_Q;
          end else begin
            err_nxt    = 1'b1;
            next_state = HUNT_I;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        i_hold <= '0;
    else if (hold_ld) i_hold <= d_r;
  end

  // Lock is lost on the same edge as a sync error or a drop back to IDLE.
  always_ff @(posedge clk) begin
    if (reset || err_nxt || next_state == IDLE)
      good_cnt <= '0;
    else if (push && good_cnt != CW'(LOCK_PAIRS))
      good_cnt <= good_cnt + CW'(1);
  end

  assign locked = (good_cnt == CW'(LOCK_PAIRS));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      sync_err <= err_nxt;
      if (err_nxt && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  // ---- output FIFO stage
  assign pop     = (fifo_level != '0) && bus.iq_ready;
  assign full    = (fifo_level == LW'(FIFO_DEPTH));
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {i_hold, d_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Head is forced to zero while empty so stale storage never shows on the bus.
  assign bus.iq_valid = (fifo_level != '0);
  assign bus.iq_data  = bus.iq_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_afe_rx_iq_deinterleaver.sv
// Directed bench for afe_rx_iq_deinterleaver; a second instance with a 2-bit error
// counter shares the same stimulus to exercise counter saturation.
module tb_afe_rx_iq_deinterleaver;

  logic       clk;
  logic       reset;
  logic       en;
  logic       ovf_clr;
  logic       locked, sync_err, overflow;
  logic [7:0] err_cnt;
  logic [3:0] fifo_level;
  logic       locked2, sync_err2, overflow2;
  logic [1:0] err_cnt2;
  logic [3:0] fifo_level2;

  int n_cmp = 0;
  int n_err = 0;

  afe_rx_iq_deinterleaver_if #(.SAMPLE_WIDTH(12)) bus ();
  afe_rx_iq_deinterleaver_if #(.SAMPLE_WIDTH(12)) bus2 ();

  assign bus2.afe_rx_d   = bus.afe_rx_d;
  assign bus2.afe_rx_sel = bus.afe_rx_sel;
  assign bus2.iq_ready   = bus.iq_ready;

  afe_rx_iq_deinterleaver #(
    .SAMPLE_WIDTH(12), .FIFO_DEPTH(8), .LOCK_PAIRS(4), .ERR_CNT_WIDTH(8)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .bus(bus),
    .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt),
    .overflow(overflow), .ovf_clr(ovf_clr), .fifo_level(fifo_level)
  );

  afe_rx_iq_deinterleaver #(
    .SAMPLE_WIDTH(12), .FIFO_DEPTH(8), .LOCK_PAIRS(4), .ERR_CNT_WIDTH(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .bus(bus2),
    .locked(locked2), .sync_err(sync_err2), .err_cnt(err_cnt2),
    .overflow(overflow2), .ovf_clr(ovf_clr), .fifo_level(fifo_level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic sel, input logic [11:0] d);
    bus.afe_rx_sel = sel;
    bus.afe_rx_d   = d;
    tick();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    en             = 1'b0;
    bus.afe_rx_sel = 1'b0;
    bus.afe_rx_d   = '0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pair(input logic [11:0] i, input logic [11:0] q);
    return {8'h00, i, q};
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; ovf_clr = 1'b0;
    bus.afe_rx_sel = 1'b0; bus.afe_rx_d = '0; bus.iq_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_valid", 32'(bus.iq_valid), 0);
    chk("rst_data", 32'(bus.iq_data), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_level", 32'(fifo_level), 0);

    // 1: clean stream, latency and lock
    bus.iq_ready = 1'b1;
    en = 1'b1;
    for (int p = 0; p < 6; p++) begin
      word(1'b1, 12'h123);
      if (p >= 1) begin
        chk("t1_valid", 32'(bus.iq_valid), 1);
        chk("t1_data", 32'(bus.iq_data), 32'h0012_3456);
      end
      chk("t1_locked", 32'(locked), (p >= 4) ? 1 : 0);
      word(1'b0, 12'h456);
      chk("t1_valid_gap", 32'(bus.iq_valid), 0);
    end

    // 2: I,Q then I=A, I=B, Q -> one error, {B,Q} output
    word(1'b1, 12'h123);
    chk("t1_sixth", 32'(bus.iq_data), 32'h0012_3456);
    chk("t1_locked_end", 32'(locked), 1);
    word(1'b0, 12'h456);
    word(1'b1, 12'hAAA);
    chk("t2_data_pre", 32'(bus.iq_data), 32'h0012_3456);
    chk("t2_locked_pre", 32'(locked), 1);
    word(1'b1, 12'hBBB);
    chk("t2_no_err_yet", 32'(sync_err), 0);
    word(1'b0, 12'h456);
    chk("t2_sync_err", 32'(sync_err), 1);
    chk("t2_err_cnt", 32'(err_cnt), 1);
    chk("t2_err_cnt2", 32'(err_cnt2), 1);
    chk("t2_locked", 32'(locked), 0);
    word(1'b1, 12'h321);
    chk("t2_pulse_end", 32'(sync_err), 0);
    chk("t2_valid", 32'(bus.iq_valid), 1);
    chk("t2_data_bq", 32'(bus.iq_data), pair(12'hBBB, 12'h456));
    word(1'b0, 12'h654);
    chk("t2_drained", 32'(bus.iq_valid), 0);
    en = 1'b0;
    tick();
    chk("t2_en_off_no_push", 32'(fifo_level), 0);
    chk("t2_err_cnt_hold", 32'(err_cnt), 1);

    // 3: overflow with consumer stalled
    do_reset();
    bus.iq_ready = 1'b0;
    en = 1'b1;
    for (int p = 0; p < 10; p++) begin
      word(1'b1, 12'(12'h100 + p));
      if (p == 8) begin
        chk("t3_full_level", 32'(fifo_level), 8);
        chk("t3_no_ovf_yet", 32'(overflow), 0);
      end
      if (p == 9) chk("t3_ovf_set", 32'(overflow), 1);
      word(1'b0, 12'(12'h200 + p));
    end
    word(1'b0, 12'h000);
    en = 1'b0;
    word(1'b0, 12'h000);
    chk("t3_level", 32'(fifo_level), 8);
    chk("t3_overflow", 32'(overflow), 1);
    bus.iq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_drain_valid", 32'(bus.iq_valid), 1);
      chk("t3_drain_data", 32'(bus.iq_data), pair(12'(12'h100 + k), 12'(12'h200 + k)));
      tick();
    end
    chk("t3_empty", 32'(bus.iq_valid), 0);
    chk("t3_empty_level", 32'(fifo_level), 0);
    chk("t3_empty_data", 32'(bus.iq_data), 0);
    chk("t3_ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);

    // 4: push and pop on the same edge while full
    do_reset();
    bus.iq_ready = 1'b0;
    en = 1'b1;
    for (int p = 0; p < 8; p++) begin
      word(1'b1, 12'(12'h300 + p));
      word(1'b0, 12'(12'h400 + p));
    end
    word(1'b1, 12'h308);
    chk("t4_full", 32'(fifo_level), 8);
    word(1'b0, 12'h408);
    chk("t4_full_hold", 32'(fifo_level), 8);
    bus.iq_ready = 1'b1;
    word(1'b1, 12'h999);
    en = 1'b0;
    bus.iq_ready = 1'b0;
    chk("t4_level_same", 32'(fifo_level), 8);
    chk("t4_no_ovf", 32'(overflow), 0);
    chk("t4_new_head", 32'(bus.iq_data), pair(12'h301, 12'h401));
    tick();
    bus.iq_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("t4_drain", 32'(bus.iq_data), pair(12'(12'h300 + k), 12'(12'h400 + k)));
      tick();
    end
    chk("t4_empty", 32'(fifo_level), 0);

    // 5: en dropped between I and Q, resumed on a Q word
    do_reset();
    bus.iq_ready = 1'b1;
    en = 1'b1;
    word(1'b1, 12'h5A5);
    word(1'b0, 12'h777);
    en = 1'b0;
    word(1'b0, 12'h777);
    chk("t5_no_push", 32'(fifo_level), 0);
    chk("t5_no_err_off", 32'(sync_err), 0);
    en = 1'b1;
    word(1'b0, 12'h888);
    chk("t5_no_err_idle", 32'(sync_err), 0);
    word(1'b1, 12'h5B5);
    chk("t5_no_err_hunt", 32'(sync_err), 0);
    chk("t5_no_valid", 32'(bus.iq_valid), 0);
    word(1'b0, 12'h5C5);
    chk("t5_no_valid2", 32'(bus.iq_valid), 0);
    word(1'b1, 12'h999);
    chk("t5_valid", 32'(bus.iq_valid), 1);
    chk("t5_data", 32'(bus.iq_data), pair(12'h5B5, 12'h5C5));
    chk("t5_err_cnt", 32'(err_cnt), 0);
    en = 1'b0;
    tick();

    // 6: counter saturation, then reset mid-stream
    do_reset();
    bus.iq_ready = 1'b0;
    en = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      word(1'b1, 12'(12'h600 + n));
      if (n == 2) chk("t6_cnt2_start", 32'(err_cnt2), 0);
      if (n == 4) chk("t6_cnt2_two", 32'(err_cnt2), 2);
      if (n == 5) chk("t6_cnt2_three", 32'(err_cnt2), 3);
      if (n == 6) chk("t6_cnt2_sat", 32'(err_cnt2), 3);
      if (n >= 3) chk("t6_pulse", 32'(sync_err), 1);
    end
    chk("t6_err_cnt8", 32'(err_cnt), 5);
    chk("t6_err_cnt2_final", 32'(err_cnt2), 3);
    chk("t6_locked", 32'(locked), 0);
    en = 1'b0;
    tick();
    chk("t6_en_off_no_err", 32'(sync_err), 0);
    en = 1'b1;
    word(1'b1, 12'hAB1);
    word(1'b0, 12'hCD2);
    word(1'b1, 12'hAB3);
    chk("t6_level_one", 32'(fifo_level), 1);
    chk("t6_head", 32'(bus.iq_data), pair(12'hAB1, 12'hCD2));
    reset = 1'b1;
    tick();
    chk("t6r_valid", 32'(bus.iq_valid), 0);
    chk("t6r_data", 32'(bus.iq_data), 0);
    chk("t6r_locked", 32'(locked), 0);
    chk("t6r_sync_err", 32'(sync_err), 0);
    chk("t6r_err_cnt", 32'(err_cnt), 0);
    chk("t6r_err_cnt2", 32'(err_cnt2), 0);
    chk("t6r_overflow", 32'(overflow), 0);
    chk("t6r_level", 32'(fifo_level), 0);
    reset = 1'b0;
    en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
